mul_sequencer: RTL and testbench
================================

// Module: mul_sequencer
// PURPOSE
//  Multi-cycle controller for the unsigned 32x32->64 multiply used by the F_MULLO and F_MULHI ALU functions.
//  Runs an iterative shift-add engine and stalls the pipeline while it works.
//  Caches the last 64-bit product, so a MULHI/MULLO pair on the same operands computes only once.
//  Sits beside alu; the datapath muxes mul_r into alu_r when func is a multiply.
// PARAMETERS
//  WIDTH          32  operand width; product is 2*WIDTH
//  BITS_PER_CYCLE 1   multiplier bits retired per RUN cycle; legal 1,2,4; must divide WIDTH
// PORTS
//  clk       in   1      system clock, rising edge
//  rst       in   1      synchronous, active-high reset
//  req       in   1      stage holds a valid ALU op this cycle
//  func      in   6      ALU function code (F_* from constant_params.vh)
//  op_a      in   WIDTH  multiplicand (rfa)
//  op_b      in   WIDTH  multiplier (rfb or imm32 after the aluy mux)
//  flush     in   1      abort any multiply in progress (branch or exception kill)
//  stall     out  1      hold the pipeline; combinational from state and inputs
//  mul_r     out  WIDTH  F_MULLO: product[WIDTH-1:0]; F_MULHI: product[2W-1:W]
//  mul_done  out  1      1-cycle pulse when a fresh product is written to the cache
// BEHAVIOUR
//  - mul = req & (func==F_MULLO | func==F_MULHI); other funcs give stall=0 and are ignored.
//  - hit = cache_vld & op_a==a_q & op_b==b_q; a_q/b_q are the operands of the cached product.
//  - N = WIDTH/BITS_PER_CYCLE (32 at default).
//  - States: IDLE, RUN, DONE.
//  - IDLE, mul & hit: stall=0; mul_r is driven from the cache in the same cycle (0-cycle latency).
//  - IDLE, mul & !hit: stall=1; latch op_a/op_b into the working regs; clear the 2W accumulator and counter; go to RUN.
//  - RUN: stall=1; each cycle add the shifted multiplicand for BITS_PER_CYCLE multiplier bits and increment the counter.
//    After N RUN cycles, go to DONE.
//  - DONE: write product/a_q/b_q; set cache_vld; mul_done=1; stall=0 iff hit against the newly written values.
//    Writes are bypassed so the comparison sees them in this same cycle; next state is IDLE.
//  - DONE with no hit (operands changed mid-run): stall stays 1 and DONE goes directly to RUN with the new operands latched.
//    The cache still holds the completed product.
//  - Miss latency: stall is high for N+1 cycles (33 at default); the result is valid in DONE.
//  - Requester: must hold req/func/op_* stable while stall=1. Any change is tolerated only as described under DONE.
//  - flush in RUN or DONE: next state is IDLE and cache_vld is cleared. stall goes to 0 the cycle after flush.
//    The same-cycle stall is still computed normally.
//  - flush and a mul miss in IDLE in the same cycle: flush wins; no run starts and stall=0.
//  - rst: state=IDLE, cache_vld=0, a_q=b_q=0, product=0, counter=0. Outputs: stall=0, mul_r=0, mul_done=0.
//    rst mid-RUN discards the partial product.
//  - mul_r = 0 whenever cache_vld=0. Arithmetic is unsigned modulo 2^(2W); no overflow flag.
//  - func may switch between MULLO and MULHI with the same operands; this is a hit and does not stall.
// TESTING
//  1. rst; mulhi a=0x0FFFFFFF b=0x00003000 -> stall high for 33 cycles, then mul_r=0x000002FF, mul_done pulses once.
//  2. Next cycle, mullo with the same operands -> stall=0 in the same cycle, mul_r=0xFFFFD000, no mul_done.
//  3. mullo a=b=0xFFFFFFFF -> after 33 cycles mul_r=0x00000001; then mulhi -> hit, mul_r=0xFFFFFFFE.
//  4. mullo 6*4; flush on RUN cycle 10 -> stall=0 next cycle, mul_r=0; reissue -> full 33-cycle stall, mul_r=0x18.
//  5. rst asserted mid-RUN -> next cycle stall=0, mul_r=0, mul_done=0; func=F_ADD with req -> stall=0.
//  6. BITS_PER_CYCLE=4: mulhi 0x80000000*0x4 -> stall for 9 cycles, mul_r=0x00000002;
//     operand change mid-run -> DONE restarts, total stall 18 cycles.

Source files
------------

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - iterative shift-add 32x32->64 multiply sequencer with a one-entry product cache
//
// Ports:
//   clk       in   1      system clock, rising edge
//   rst       in   1      synchronous active-high reset
//   req       in   1      stage holds a valid ALU op this cycle
//   func      in   6      ALU function code; F_MULLO / F_MULHI select a multiply
//   op_a      in   WIDTH  multiplicand
//   op_b      in   WIDTH  multiplier
//   flush     in   1      abort any multiply in progress and invalidate the cache
//   stall     out  1      hold the pipeline (combinational)
//   mul_r     out  WIDTH  low or high half of the cached (or just-finished) product
//   mul_done  out  1      one-cycle pulse when a fresh product is written to the cache
module mul_sequencer #(
    parameter int         WIDTH          = 32,
    parameter int         BITS_PER_CYCLE = 1,
    parameter logic [5:0] F_MULLO        = 6'h18,
    parameter logic [5:0] F_MULHI        = 6'h19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             stall,
    output logic [WIDTH-1:0] mul_r,
    output logic             mul_done
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state_q,     state_d;
    logic [CW-1:0]      cnt_q,       cnt_d;
    logic [2*WIDTH-1:0] mcand_q,     mcand_d;
    logic [WIDTH-1:0]   mplier_q,    mplier_d;
    logic [2*WIDTH-1:0] acc_q,       acc_d;
    logic [WIDTH-1:0]   opa_q,       opa_d;
    logic [WIDTH-1:0]   opb_q,       opb_d;
    logic [2*WIDTH-1:0] prod_q,      prod_d;
    logic [WIDTH-1:0]   a_q,         a_d;
    logic [WIDTH-1:0]   b_q,         b_d;
    logic               cache_vld_q, cache_vld_d;

    logic               is_mul;
    logic               hit;
    logic               hit_new;
    logic [2*WIDTH-1:0] partial;
    logic               src_vld;
    logic [2*WIDTH-1:0] src;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        prod_d      = prod_q;
        a_d         = a_q;
        b_d         = b_q;
        cache_vld_d = cache_vld_q;
        stall       = 1'b0;
        mul_done    = 1'b0;

        is_mul  = req && (func == F_MULLO || func == F_MULHI);
        hit     = cache_vld_q && op_a == a_q && op_b == b_q;
        // In DONE the cache write is bypassed: compare against the operands just finished.
        hit_new = op_a == opa_q && op_b == opb_q;

        // Shift-add for the low BITS_PER_CYCLE multiplier bits of this step.
        partial = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (mplier_q[k]) begin
                partial = partial + (mcand_q << k);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (is_mul && !hit && !flush) begin
                    stall    = 1'b1;
                    opa_d    = op_a;
                    opb_d    = op_b;
                    mcand_d  = {{WIDTH{1'b0}}, op_a};
                    mplier_d = op_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                stall    = 1'b1;
                acc_d    = acc_q + partial;
                mcand_d  = mcand_q << BITS_PER_CYCLE;
                mplier_d = mplier_q >> BITS_PER_CYCLE;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_DONE;
                end
                if (flush) begin
                    state_d     = S_IDLE;
                    cache_vld_d = 1'b0;
                end
            end
            S_DONE: begin
                mul_done    = 1'b1;
                prod_d      = acc_q;
                a_d         = opa_q;
                b_d         = opb_q;
                cache_vld_d = 1'b1;
                state_d     = S_IDLE;
                // Operands moved while we ran: keep the finished product cached and start over.
                if (is_mul && !hit_new) begin
                    stall    = 1'b1;
                    opa_d    = op_a;
                    opb_d    = op_b;
                    mcand_d  = {{WIDTH{1'b0}}, op_a};
                    mplier_d = op_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
                if (flush) begin
                    state_d     = S_IDLE;
                    cache_vld_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        src_vld = (state_q == S_DONE) || cache_vld_q;
        src     = (state_q == S_DONE) ? acc_q : prod_q;
        if (!src_vld) begin
            mul_r = '0;
        end else if (func == F_MULHI) begin
            mul_r = src[2*WIDTH-1:WIDTH];
        end else begin
            mul_r = src[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            prod_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cache_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            prod_q      <= prod_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cache_vld_q <= cache_vld_d;
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - directed self-checking bench for mul_sequencer
module tb_mul_sequencer;

    localparam logic [5:0] F_MULLO = 6'h18;
    localparam logic [5:0] F_MULHI = 6'h19;
    localparam logic [5:0] F_ADD   = 6'h00;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req, flush, stall, mul_done;
    logic [5:0]  func;
    logic [31:0] op_a, op_b, mul_r;

    logic        rst4, req4, flush4, stall4, mul_done4;
    logic [5:0]  func4;
    logic [31:0] op_a4, op_b4, mul_r4;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc, dn;

    mul_sequencer #(.WIDTH(32), .BITS_PER_CYCLE(1), .F_MULLO(F_MULLO), .F_MULHI(F_MULHI)) u_dut (
        .clk(clk), .rst(rst), .req(req), .func(func), .op_a(op_a), .op_b(op_b),
        .flush(flush), .stall(stall), .mul_r(mul_r), .mul_done(mul_done)
    );

    mul_sequencer #(.WIDTH(32), .BITS_PER_CYCLE(4), .F_MULLO(F_MULLO), .F_MULHI(F_MULHI)) u_dut4 (
        .clk(clk), .rst(rst4), .req(req4), .func(func4), .op_a(op_a4), .op_b(op_b4),
        .flush(flush4), .stall(stall4), .mul_r(mul_r4), .mul_done(mul_done4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_stall(output int cycles, output int dones);
        cycles = 0;
        dones  = 0;
        while (stall === 1'b1 && cycles < 200) begin
            cycles++;
            dones += int'(mul_done);
            tick();
            #1;
        end
        dones += int'(mul_done);
    endtask

    task automatic wait_stall4(output int cycles, output int dones);
        cycles = 0;
        dones  = 0;
        while (stall4 === 1'b1 && cycles < 200) begin
            cycles++;
            dones += int'(mul_done4);
            tick();
            #1;
        end
        dones += int'(mul_done4);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; func = F_ADD; op_a = '0; op_b = '0; flush = 1'b0;
        rst4 = 1'b1; req4 = 1'b0; func4 = F_ADD; op_a4 = '0; op_b4 = '0; flush4 = 1'b0;
        repeat (3) tick();
        rst = 1'b0; rst4 = 1'b0;
        #1;
        check("rst_stall", stall, 1'b0);
        check("rst_mul_r", mul_r, 32'h0);
        check("rst_done", mul_done, 1'b0);
        check("rst4_stall", stall4, 1'b0);
        check("rst4_mul_r", mul_r4, 32'h0);
        check("rst4_done", mul_done4, 1'b0);

        // 1: mulhi miss
        tick();
        req = 1'b1; func = F_MULHI; op_a = 32'h0FFF_FFFF; op_b = 32'h0000_3000;
        #1;
        wait_stall(cyc, dn);
        check("t1_stall_cycles", cyc, 33);
        check("t1_mul_r", mul_r, 32'h0000_02FF);
        check("t1_done_now", mul_done, 1'b1);
        check("t1_done_pulses", dn, 1);

        // 2: mullo same operands hits
        tick();
        func = F_MULLO;
        #1;
        check("t2_stall", stall, 1'b0);
        check("t2_mul_r", mul_r, 32'hFFFF_D000);
        check("t2_done", mul_done, 1'b0);

        // 3: all-ones operands
        tick();
        op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
        #1;
        wait_stall(cyc, dn);
        check("t3_stall_cycles", cyc, 33);
        check("t3_mullo", mul_r, 32'h0000_0001);
        tick();
        func = F_MULHI;
        #1;
        check("t3_hit_stall", stall, 1'b0);
        check("t3_mulhi", mul_r, 32'hFFFF_FFFE);
        check("t3_hit_done", mul_done, 1'b0);

        // 4: flush on RUN cycle 10, then flush in IDLE beats a miss, then reissue
        tick();
        func = F_MULLO; op_a = 32'd6; op_b = 32'd4;
        #1;
        check("t4_issue_stall", stall, 1'b1);
        repeat (10) tick();
        flush = 1'b1;
        #1;
        check("t4_flush_cycle_stall", stall, 1'b1);
        tick();
        check("t4_after_flush_stall", stall, 1'b0);
        check("t4_after_flush_mul_r", mul_r, 32'h0);
        tick();
        check("t4_idle_flush_stall", stall, 1'b0);
        flush = 1'b0;
        #1;
        wait_stall(cyc, dn);
        check("t4_reissue_cycles", cyc, 33);
        check("t4_mul_r", mul_r, 32'h18);

        // 5: reset mid-run
        tick();
        op_a = 32'd3; op_b = 32'd5;
        #1;
        repeat (5) tick();
        rst = 1'b1; req = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("t5_stall", stall, 1'b0);
        check("t5_mul_r", mul_r, 32'h0);
        check("t5_done", mul_done, 1'b0);
        req = 1'b1; func = F_ADD;
        #1;
        check("t5_add_stall", stall, 1'b0);
        check("t5_add_mul_r", mul_r, 32'h0);
        tick();
        func = F_MULLO;
        #1;
        wait_stall(cyc, dn);
        check("t5_rerun_cycles", cyc, 33);
        check("t5_mul_r", mul_r, 32'd15);

        // 6: four bits per cycle, then operand change mid-run
        tick();
        req = 1'b0;
        req4 = 1'b1; func4 = F_MULHI; op_a4 = 32'h8000_0000; op_b4 = 32'h4;
        #1;
        wait_stall4(cyc, dn);
        check("t6_stall_cycles", cyc, 9);
        check("t6_mul_r", mul_r4, 32'h2);
        check("t6_done", mul_done4, 1'b1);
        tick();
        func4 = F_MULLO; op_a4 = 32'd7; op_b4 = 32'd9;
        #1;
        cyc = 0;
        dn  = 0;
        while (stall4 === 1'b1 && cyc < 200) begin
            cyc++;
            dn += int'(mul_done4);
            tick();
            if (cyc == 3) begin
                op_a4 = 32'h10; op_b4 = 32'h10;
            end
            #1;
        end
        dn += int'(mul_done4);
        check("t6_restart_cycles", cyc, 18);
        check("t6_restart_pulses", dn, 2);
        check("t6_restart_mul_r", mul_r4, 32'h100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
